alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, number of cycles (1..15) operands are held on the shared ALU before its result is sampled.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have req0_valid/req1_valid  input  1 each  requester n presents an operation.
REQ-005 SHALL have req0_ready/req1_ready  output  1 each  operation of requester n accepted this cycle.
REQ-006 SHALL have req0_op/req1_op  input  4 each; req0_a/req1_a, req0_b/req1_b  input  32 each; req0_shamt/req1_shamt  input  5 each  operation fields.
REQ-007 SHALL have alu_op 4, alu_a 32, alu_b 32, alu_shamt 5  outputs  drive the shared 32-bit ALU.
REQ-008 SHALL have alu_result  input  32 and alu_zero  input  1  from the shared ALU.
REQ-009 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (granted requester), rsp_result output 32, rsp_zero output 1.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-011 In IDLE with any reqN_valid high, SHALL grant exactly one requester, assert its reqN_ready combinationally that cycle, latch op/a/b/shamt and id, and enter EXEC next cycle.
REQ-012 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-013 In EXEC, alu_* SHALL be driven from latched fields; an internal counter SHALL count EXEC_CYCLES cycles, and on the last one alu_result/alu_zero SHALL be captured into rsp_result/rsp_zero and the FSM SHALL enter RESP.
REQ-014 In RESP, rsp_valid SHALL be high and rsp_result/rsp_zero/rsp_id stable until rsp_ready is sampled high; then FSM SHALL return to IDLE.
REQ-015 Latency: request accepted in cycle T SHALL give rsp_valid first high in cycle T+EXEC_CYCLES+1; max throughput one operation per EXEC_CYCLES+2 cycles.
REQ-016 alu_* outputs SHALL hold last latched values outside EXEC.
REQ-017 op codes are passed through unchanged, including undefined codes 8..15 (ALU returns 0, zero=1).
REQ-018 Requests arriving while not in IDLE SHALL not be accepted; requesters hold valid and fields until ready.

Reset
REQ-019 reset SHALL force IDLE, counter 0, priority pointer to requester 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, alu_op/alu_a/alu_b/alu_shamt 0, both reqN_ready 0 in that cycle.
REQ-020 reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response SHALL be produced.

Configuration
REQ-021 With macro ALU_ARB_ROUND_ROBIN_EN defined, SHALL grant on simultaneous valid the requester indicated by a priority pointer, which flips to the other requester after each accepted grant.
REQ-022 Without ALU_ARB_ROUND_ROBIN_EN, SHALL use fixed priority: requester 0 always wins simultaneous requests; no pointer register.
REQ-023 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-024 EXEC_CYCLES=1, req0 op=ADD(3) a=5 b=7 accepted at T -> rsp_valid at T+2, rsp_result=12, rsp_zero=0, rsp_id=0.
REQ-025 req1 op=SUB(4) a=9 b=9, rsp_ready held low 3 cycles -> rsp_valid stays high, result=0, zero=1, no new grant until rsp_ready.
REQ-026 Both valid continuously, 4 ops, macro defined -> grant order 0,1,0,1; macro undefined -> 0,0,0,0 with req1_ready never high.
REQ-027 EXEC_CYCLES=3, req0 op=SLL(5) a=1 shamt=4 -> alu_* stable 3 cycles, rsp_result=16 at T+4.
REQ-028 reset pulsed in EXEC -> next cycle IDLE, rsp_valid=0, all outputs 0, no stale response after reset release.
REQ-029 req0 op=15 a=1 b=1 -> rsp_result=0, rsp_zero=1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_shamt;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_shamt;

    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_shamt,
        input  req1_valid, req1_op, req1_a, req1_b, req1_shamt,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b, alu_shamt,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_shamt,
        output req1_valid, req1_op, req1_a, req1_b, req1_shamt,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b, alu_shamt,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared 32-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority to requester 0.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_shamt;
    logic        r_id;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;

    logic        w_accept;
    logic        w_sel1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic        r_ptr;
    // Pointer only matters on a tie; a lone requester always wins.
    assign w_sel1 = bus.req1_valid & (~bus.req0_valid | r_ptr);
`else
    assign w_sel1 = bus.req1_valid & ~bus.req0_valid;
`endif

    assign w_accept       = (r_state == IDLE) & ~reset & (bus.req0_valid | bus.req1_valid);
    assign bus.req0_ready = w_accept & ~w_sel1;
    assign bus.req1_ready = w_accept &  w_sel1;

    assign bus.alu_op     = r_op;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_shamt  = r_shamt;

    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_shamt      <= '0;
            r_id         <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            r_ptr        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_sel1 ? bus.req1_op    : bus.req0_op;
                        r_a     <= w_sel1 ? bus.req1_a     : bus.req0_a;
                        r_b     <= w_sel1 ? bus.req1_b     : bus.req0_b;
                        r_shamt <= w_sel1 ? bus.req1_shamt : bus.req0_shamt;
                        r_id    <= w_sel1;
                        r_cnt   <= '0;
                        r_state <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        r_ptr   <= ~w_sel1;
`endif
                    end
                end
                EXEC: begin
                    if (r_cnt == LAST_CNT) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_zero   <= bus.alu_zero;
                        r_cnt        <= '0;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=3,
// each in front of a behavioural ALU. Inputs change and outputs are checked on the falling edge.
module tb_alu_arbiter;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    alu_arbiter_if ifa ();
    alu_arbiter_if ifb ();

    alu_arbiter #(.EXEC_CYCLES(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    alu_arbiter #(.EXEC_CYCLES(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        ifa.alu_result = alu_f(ifa.alu_op, ifa.alu_a, ifa.alu_b, ifa.alu_shamt);
        ifa.alu_zero   = (ifa.alu_result == 32'd0);
        ifb.alu_result = alu_f(ifb.alu_op, ifb.alu_a, ifb.alu_b, ifb.alu_shamt);
        ifb.alu_zero   = (ifb.alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.req0_valid = 0; ifa.req0_op = 0; ifa.req0_a = 0; ifa.req0_b = 0; ifa.req0_shamt = 0;
        ifa.req1_valid = 0; ifa.req1_op = 0; ifa.req1_a = 0; ifa.req1_b = 0; ifa.req1_shamt = 0;
        ifa.rsp_ready  = 0;
        ifb.req0_valid = 0; ifb.req0_op = 0; ifb.req0_a = 0; ifb.req0_b = 0; ifb.req0_shamt = 0;
        ifb.req1_valid = 0; ifb.req1_op = 0; ifb.req1_a = 0; ifb.req1_b = 0; ifb.req1_shamt = 0;
        ifb.rsp_ready  = 0;
    endtask

    logic exp_id;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b1;
        ifa.req0_valid = 1;
        cyc();
        cyc();
        // Reset state, with a request pending that must not be granted.
        chk("rst_ready0", ifa.req0_ready, 0);
        chk("rst_ready1", ifa.req1_ready, 0);
        chk("rst_rsp_valid", ifa.rsp_valid, 0);
        chk("rst_rsp_id", ifa.rsp_id, 0);
        chk("rst_rsp_result", ifa.rsp_result, 0);
        chk("rst_rsp_zero", ifa.rsp_zero, 0);
        chk("rst_alu_op", ifa.alu_op, 0);
        chk("rst_alu_a", ifa.alu_a, 0);
        chk("rst_alu_b", ifa.alu_b, 0);
        chk("rst_alu_shamt", ifa.alu_shamt, 0);

        // ADD 5+7 from requester 0: response two cycles after acceptance.
        reset = 1'b0;
        ifa.req0_op = 4'd3; ifa.req0_a = 5; ifa.req0_b = 7;
        #1;
        chk("add_ready0", ifa.req0_ready, 1);
        chk("add_ready1", ifa.req1_ready, 0);
        cyc();
        ifa.req0_valid = 0;
        #1;
        chk("add_exec_valid", ifa.rsp_valid, 0);
        chk("add_alu_op", ifa.alu_op, 3);
        chk("add_alu_a", ifa.alu_a, 5);
        chk("add_alu_b", ifa.alu_b, 7);
        cyc();
        chk("add_rsp_valid", ifa.rsp_valid, 1);
        chk("add_rsp_result", ifa.rsp_result, 12);
        chk("add_rsp_zero", ifa.rsp_zero, 0);
        chk("add_rsp_id", ifa.rsp_id, 0);
        ifa.rsp_ready = 1;
        cyc();
        ifa.rsp_ready = 0;
        chk("add_back_idle", ifa.rsp_valid, 0);

        // SUB 9-9 from requester 1, response back-pressured for three cycles.
        ifa.req1_valid = 1; ifa.req1_op = 4'd4; ifa.req1_a = 9; ifa.req1_b = 9;
        #1;
        chk("sub_ready1", ifa.req1_ready, 1);
        chk("sub_ready0", ifa.req0_ready, 0);
        cyc();
        ifa.req1_valid = 0;
        ifa.req0_valid = 1; ifa.req0_op = 4'd3; ifa.req0_a = 1; ifa.req0_b = 1;
        #1;
        chk("sub_exec_no_grant", ifa.req0_ready, 0);
        cyc();
        chk("sub_rsp_result", ifa.rsp_result, 0);
        chk("sub_rsp_zero", ifa.rsp_zero, 1);
        chk("sub_rsp_id", ifa.rsp_id, 1);
        for (int i = 0; i < 3; i++) begin
            chk("sub_hold_valid", ifa.rsp_valid, 1);
            chk("sub_hold_result", ifa.rsp_result, 0);
            chk("sub_hold_no_grant", ifa.req0_ready, 0);
            if (i < 2) cyc();
        end
        ifa.rsp_ready = 1;
        cyc();
        ifa.rsp_ready = 0;
        #1;
        chk("post_hold_grant0", ifa.req0_ready, 1);
        cyc();
        ifa.req0_valid = 0;
        cyc();
        chk("post_hold_result", ifa.rsp_result, 2);
        chk("post_hold_id", ifa.rsp_id, 0);
        ifa.rsp_ready = 1;
        cyc();

        // Reset restores the priority pointer, then both requesters compete continuously.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ifa.rsp_ready  = 1;
        ifa.req0_valid = 1; ifa.req0_op = 4'd3; ifa.req0_a = 10; ifa.req0_b = 0;
        ifa.req1_valid = 1; ifa.req1_op = 4'd3; ifa.req1_a = 20; ifa.req1_b = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_id = k[0];
`else
            exp_id = 1'b0;
`endif
            chk("both_ready0", ifa.req0_ready, !exp_id);
            chk("both_ready1", ifa.req1_ready, exp_id);
            cyc();
            chk("both_exec_ready", ifa.req0_ready | ifa.req1_ready, 0);
            cyc();
            chk("both_rsp_id", ifa.rsp_id, exp_id);
            chk("both_rsp_result", ifa.rsp_result, exp_id ? 20 : 10);
            cyc();
        end
        ifa.req0_valid = 0;
        ifa.req1_valid = 0;
        ifa.rsp_ready  = 0;
        cyc();

        // Undefined op 15 is passed through; the ALU returns zero.
        ifa.req0_valid = 1; ifa.req0_op = 4'd15; ifa.req0_a = 1; ifa.req0_b = 1;
        cyc();
        ifa.req0_valid = 0;
        #1;
        chk("op15_alu_op", ifa.alu_op, 15);
        cyc();
        chk("op15_valid", ifa.rsp_valid, 1);
        chk("op15_result", ifa.rsp_result, 0);
        chk("op15_zero", ifa.rsp_zero, 1);
        ifa.rsp_ready = 1;
        cyc();
        ifa.rsp_ready = 0;

        // Reset while in EXEC drops the operation.
        ifa.req0_valid = 1; ifa.req0_op = 4'd3; ifa.req0_a = 3; ifa.req0_b = 4;
        cyc();
        ifa.req0_valid = 0;
        reset = 1'b1;
        cyc();
        chk("rexec_valid", ifa.rsp_valid, 0);
        chk("rexec_alu_op", ifa.alu_op, 0);
        chk("rexec_alu_a", ifa.alu_a, 0);
        chk("rexec_alu_b", ifa.alu_b, 0);
        chk("rexec_result", ifa.rsp_result, 0);
        reset = 1'b0;
        ifa.rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rexec_no_stale", ifa.rsp_valid, 0);
        end
        ifa.rsp_ready = 0;

        // EXEC_CYCLES=3: SLL 1<<4, ALU inputs stable for three cycles, response at T+4.
        ifb.req0_valid = 1; ifb.req0_op = 4'd5; ifb.req0_a = 1; ifb.req0_b = 0; ifb.req0_shamt = 4;
        #1;
        chk("sll_ready0", ifb.req0_ready, 1);
        cyc();
        ifb.req0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sll_alu_op", ifb.alu_op, 5);
            chk("sll_alu_a", ifb.alu_a, 1);
            chk("sll_alu_shamt", ifb.alu_shamt, 4);
            chk("sll_not_yet", ifb.rsp_valid, 0);
            cyc();
        end
        chk("sll_rsp_valid", ifb.rsp_valid, 1);
        chk("sll_rsp_result", ifb.rsp_result, 16);
        chk("sll_rsp_zero", ifb.rsp_zero, 0);
        ifb.rsp_ready = 1;
        cyc();
        chk("sll_done", ifb.rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
